// File: rtl/fp_norm_pkg.sv
// Shared types and fp16 defaults for the normalise/round stage.
// Also holds the round-to-nearest-even increment decision.
package fp_norm_pkg;

    localparam int FP16_EXP_W   = 5;
    localparam int FP16_MAN_W   = 10;
    localparam int FP16_BIAS    = 15;
    localparam int FP16_EXP_MAX = 31;
    localparam int FP16_IN_W    = 24;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    function automatic logic rne_incr(input logic lsb, input logic guard, input logic sticky);
        return guard & (sticky | lsb);
    endfunction

endpackage

// File: rtl/fp_normalize_round_lead.sv
// Leading-one finder: reports the MSB-first position of the highest set bit
// (equivalently the leading-zero count) and whether the vector is all zero.
module fp_leading_one #(
    parameter int LEN   = 24,
    parameter int IDX_W = (LEN > 1) ? $clog2(LEN) : 1
) (
    input  logic [LEN-1:0]   vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             zero_o
);

    // Scanning upward lets the highest set bit overwrite any lower ones.
    always_comb begin
        idx_o  = '0;
        zero_o = ~|vec_i;
        for (int i = 0; i < LEN; i++) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(LEN - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_normalize_round.sv
// Two-stage normalise/round pipeline: stage 1 finds the leading one, stage 2
// shifts, rounds to nearest-even and packs the result with range flags.
module fp_normalize_round
    import fp_norm_pkg::*;
#(
    parameter int EXP_W = FP16_EXP_W,
    parameter int MAN_W = FP16_MAN_W,
    parameter int IN_W  = FP16_IN_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic                     in_sign_i,
    input  logic [EXP_W+1:0]         in_exp_i,
    input  logic [IN_W-1:0]          in_man_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [EXP_W+MAN_W:0]     out_result_o,
    output logic [2:0]               out_flags_o
);

    localparam int LZ_W    = $clog2(IN_W);
    localparam int EW      = EXP_W + 3;
    localparam int RES_W   = 1 + EXP_W + MAN_W;
    localparam int GRD_POS = IN_W - MAN_W - 2;

    localparam logic signed [EW-1:0] E_ONE  = EW'(1);
    localparam logic signed [EW-1:0] E_ZERO = '0;
    localparam logic signed [EW-1:0] E_INF  = EW'((2 ** EXP_W) - 1);

    logic                    s1_valid_q, s1_valid_d;
    logic                    s1_sign_q,  s1_sign_d;
    logic signed [EXP_W+1:0] s1_exp_q,   s1_exp_d;
    logic [IN_W-1:0]         s1_man_q,   s1_man_d;
    logic [LZ_W-1:0]         s1_lz_q,    s1_lz_d;
    logic                    s1_zero_q,  s1_zero_d;

    logic                    s2_valid_q, s2_valid_d;
    logic [RES_W-1:0]        result_q,   result_d;
    fp_flags_t               flags_q,    flags_d;

    logic                    s2_ready;
    logic                    s1_load;
    logic [LZ_W-1:0]         lo_idx;
    logic                    lo_zero;

    logic [IN_W-1:0]         norm;
    logic [MAN_W:0]          sig;
    logic                    guard;
    logic                    sticky;
    logic                    incr;
    logic                    carry;
    logic [MAN_W-1:0]        frac_rnd;
    logic signed [EW-1:0]    exp_ext;
    logic signed [EW-1:0]    lz_ext;
    logic signed [EW-1:0]    e_pre;
    logic signed [EW-1:0]    e_rnd;
    logic [RES_W-1:0]        calc_result;
    fp_flags_t               calc_flags;

    // Ready passes straight back so a full pipe still moves every cycle.
    assign s2_ready   = ~s2_valid_q | out_ready_i;
    assign in_ready_o = ~s1_valid_q | s2_ready;
    assign s1_load    = in_valid_i & in_ready_o;

    fp_leading_one #(
        .LEN   (IN_W),
        .IDX_W (LZ_W)
    ) u_lead (
        .vec_i  (in_man_i),
        .idx_o  (lo_idx),
        .zero_o (lo_zero)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_exp_d   = s1_exp_q;
        s1_man_d   = s1_man_q;
        s1_lz_d    = s1_lz_q;
        s1_zero_d  = s1_zero_q;
        if (in_ready_o) begin
            s1_valid_d = in_valid_i;
        end
        if (s1_load) begin
            s1_sign_d = in_sign_i;
            s1_exp_d  = in_exp_i;
            s1_man_d  = in_man_i;
            s1_lz_d   = lo_idx;
            s1_zero_d = lo_zero;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_man_q   <= '0;
            s1_lz_q    <= '0;
            s1_zero_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_exp_q   <= s1_exp_d;
            s1_man_q   <= s1_man_d;
            s1_lz_q    <= s1_lz_d;
            s1_zero_q  <= s1_zero_d;
        end
    end

    // A rounding carry only happens when sig is all ones, so the fraction wraps to zero.
    always_comb begin
        norm     = s1_man_q << s1_lz_q;
        sig      = norm[IN_W-1 -: MAN_W+1];
        guard    = norm[GRD_POS];
        sticky   = |norm[GRD_POS-1:0];
        incr     = rne_incr(sig[0], guard, sticky);
        carry    = (&sig) & incr;
        frac_rnd = sig[MAN_W-1:0] + {{(MAN_W-1){1'b0}}, incr};

        exp_ext  = {s1_exp_q[EXP_W+1], s1_exp_q};
        lz_ext   = {{(EW-LZ_W){1'b0}}, s1_lz_q};
        e_pre    = exp_ext + E_ONE - lz_ext;
        e_rnd    = carry ? (e_pre + E_ONE) : e_pre;

        calc_flags.overflow  = 1'b0;
        calc_flags.underflow = 1'b0;
        calc_flags.inexact   = guard | sticky;
        calc_result          = {s1_sign_q, e_rnd[EXP_W-1:0], frac_rnd};

        if (s1_zero_q) begin
            calc_result = {s1_sign_q, {(EXP_W+MAN_W){1'b0}}};
            calc_flags  = '0;
        end else if (e_rnd >= E_INF) begin
            calc_result          = {s1_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            calc_flags.overflow  = 1'b1;
            calc_flags.underflow = 1'b0;
            calc_flags.inexact   = 1'b1;
        end else if (e_rnd <= E_ZERO) begin
            calc_result          = {s1_sign_q, {(EXP_W+MAN_W){1'b0}}};
            calc_flags.overflow  = 1'b0;
            calc_flags.underflow = 1'b1;
            calc_flags.inexact   = 1'b1;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        result_d   = result_q;
        flags_d    = flags_q;
        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d = calc_result;
                flags_d  = calc_flags;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            flags_q    <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
        end
    end

    assign out_valid_o  = s2_valid_q;
    assign out_result_o = result_q;
    assign out_flags_o  = flags_q;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Directed bench for fp_normalize_round with hand-computed fp16 results,
// covering latency, rounding, range limits, backpressure and reset flush.
module tb_fp_normalize_round;

    typedef struct {
        logic        sign;
        logic [6:0]  exp;
        logic [23:0] man;
        logic [15:0] res;
        logic [2:0]  flags;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        in_sign_i;
    logic [6:0]  in_exp_i;
    logic [23:0] in_man_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] out_result_o;
    logic [2:0]  out_flags_o;

    int total = 0;
    int bad   = 0;

    vec_t dirVecs[14];
    vec_t bpVecs[4];

    always #5 clk_i = ~clk_i;

    fp_normalize_round dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_sign_i    (in_sign_i),
        .in_exp_i     (in_exp_i),
        .in_man_i     (in_man_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_result_o (out_result_o),
        .out_flags_o  (out_flags_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input logic valid);
        in_sign_i  = v.sign;
        in_exp_i   = v.exp;
        in_man_i   = v.man;
        in_valid_i = valid;
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int acc;
        int outs;
        int stale;

        // {sign, exp, man, expected result, expected {ovf, unf, inexact}}
        dirVecs[0]  = '{1'b0, 7'd15,  24'h400000, 16'h3C00, 3'b000};
        dirVecs[1]  = '{1'b0, 7'd15,  24'h7FFFFF, 16'h4000, 3'b001};
        dirVecs[2]  = '{1'b0, 7'd15,  24'h400800, 16'h3C00, 3'b001};
        dirVecs[3]  = '{1'b0, 7'd15,  24'h401800, 16'h3C02, 3'b001};
        dirVecs[4]  = '{1'b0, 7'd40,  24'h400000, 16'h7C00, 3'b101};
        dirVecs[5]  = '{1'b0, 7'd0,   24'h400000, 16'h0000, 3'b011};
        dirVecs[6]  = '{1'b1, 7'd7,   24'h000000, 16'h8000, 3'b000};
        dirVecs[7]  = '{1'b0, 7'd30,  24'h000C00, 16'h4E00, 3'b000};
        dirVecs[8]  = '{1'b0, 7'd30,  24'h7FF000, 16'h7BFF, 3'b000};
        dirVecs[9]  = '{1'b0, 7'd30,  24'h7FFFFF, 16'h7C00, 3'b101};
        dirVecs[10] = '{1'b0, 7'd1,   24'h400000, 16'h0400, 3'b000};
        dirVecs[11] = '{1'b1, 7'h7D,  24'h400000, 16'h8000, 3'b011};
        dirVecs[12] = '{1'b0, 7'd15,  24'h800000, 16'h4000, 3'b000};
        dirVecs[13] = '{1'b0, 7'd40,  24'h000001, 16'h4800, 3'b000};

        bpVecs[0] = '{1'b0, 7'd15, 24'h400000, 16'h3C00, 3'b000};
        bpVecs[1] = '{1'b0, 7'd15, 24'h7FFFFF, 16'h4000, 3'b001};
        bpVecs[2] = '{1'b0, 7'd30, 24'h000C00, 16'h4E00, 3'b000};
        bpVecs[3] = '{1'b1, 7'd15, 24'h401800, 16'hBC02, 3'b001};

        rst_i       = 1'b1;
        out_ready_i = 1'b0;
        applyStimulus(dirVecs[0], 1'b0);
        nextCycle();
        nextCycle();
        checkOutput("rst_out_valid", out_valid_o, 1'b0);
        checkOutput("rst_result", out_result_o, 16'h0000);
        checkOutput("rst_flags", out_flags_o, 3'b000);
        checkOutput("rst_in_ready", in_ready_o, 1'b1);
        rst_i       = 1'b0;
        out_ready_i = 1'b1;
        nextCycle();

        $display("[TB] directed vectors");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(dirVecs[i], 1'b1);
            #1;
            checkOutput($sformatf("dir%0d_in_ready", i), in_ready_o, 1'b1);
            nextCycle();
            applyStimulus(dirVecs[i], 1'b0);
            checkOutput($sformatf("dir%0d_valid_early", i), out_valid_o, 1'b0);
            nextCycle();
            checkOutput($sformatf("dir%0d_valid", i), out_valid_o, 1'b1);
            checkOutput($sformatf("dir%0d_result", i), out_result_o, dirVecs[i].res);
            checkOutput($sformatf("dir%0d_flags", i), out_flags_o, dirVecs[i].flags);
            nextCycle();
            checkOutput($sformatf("dir%0d_valid_drop", i), out_valid_o, 1'b0);
        end

        $display("[TB] backpressure");
        acc  = 0;
        outs = 0;
        for (int c = 0; c < 30 && outs < 4; c++) begin
            out_ready_i = (c >= 5);
            if (acc < 4) applyStimulus(bpVecs[acc], 1'b1);
            else         in_valid_i = 1'b0;
            #1;
            if (c == 2) begin
                checkOutput("bp_in_ready_low", in_ready_o, 1'b0);
                checkOutput("bp_accepted_two", acc, 2);
            end
            if (c >= 2 && c <= 4) begin
                checkOutput($sformatf("bp_hold_valid_c%0d", c), out_valid_o, 1'b1);
                checkOutput($sformatf("bp_hold_result_c%0d", c), out_result_o, 16'h3C00);
            end
            if (out_valid_o && out_ready_i) begin
                checkOutput($sformatf("bp_out%0d_result", outs), out_result_o, bpVecs[outs].res);
                checkOutput($sformatf("bp_out%0d_flags", outs), out_flags_o, bpVecs[outs].flags);
                outs++;
            end
            if (in_valid_i && in_ready_o) acc++;
            nextCycle();
        end
        in_valid_i = 1'b0;
        checkOutput("bp_out_count", outs, 4);
        checkOutput("bp_in_count", acc, 4);
        stale = 0;
        for (int c = 0; c < 4; c++) begin
            if (out_valid_o) stale++;
            nextCycle();
        end
        checkOutput("bp_no_duplicate", stale, 0);

        $display("[TB] reset with full pipe");
        out_ready_i = 1'b0;
        applyStimulus(bpVecs[1], 1'b1);
        nextCycle();
        applyStimulus(bpVecs[2], 1'b1);
        nextCycle();
        in_valid_i = 1'b0;
        checkOutput("rst2_full_valid", out_valid_o, 1'b1);
        checkOutput("rst2_full_in_ready", in_ready_o, 1'b0);
        rst_i = 1'b1;
        nextCycle();
        checkOutput("rst2_out_valid", out_valid_o, 1'b0);
        checkOutput("rst2_result", out_result_o, 16'h0000);
        checkOutput("rst2_flags", out_flags_o, 3'b000);
        checkOutput("rst2_in_ready", in_ready_o, 1'b1);
        rst_i       = 1'b0;
        out_ready_i = 1'b1;
        stale = 0;
        for (int c = 0; c < 5; c++) begin
            nextCycle();
            if (out_valid_o) stale++;
        end
        checkOutput("rst2_no_stale", stale, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
